// File: rtl/reg_wb_arbiter.sv
// Write-back scheduler: clears the register file after reset, then shares two write channels round-robin.
// Optional stall counter enabled by defining REG_WB_STATS_EN.
module reg_wb_arbiter #(
  parameter int X_LEN = 32,
  parameter int N_REQ = 4,
  parameter int SEL_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*SEL_W-1:0] req_sel,
  input  logic [N_REQ*X_LEN-1:0] req_data,
  output logic [1:0]             wb_en,
  output logic [2*SEL_W-1:0]     wb_sel,
  output logic [2*X_LEN-1:0]     wb_data,
  output logic                   init_done,
  output logic [31:0]            stat_conflicts
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = SEL_W - 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_sweep;
  logic [PW-1:0]      r_rr_ptr;
  logic [1:0]         r_wb_en;
  logic [2*SEL_W-1:0] r_wb_sel;
  logic [2*X_LEN-1:0] r_wb_data;
  logic               r_init_done;

  logic [SEL_W-1:0] w_sel [N_REQ];
  logic [X_LEN-1:0] w_data [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_sel[i]  = req_sel[i*SEL_W +: SEL_W];
    assign w_data[i] = req_data[i*X_LEN +: X_LEN];
  end

  logic             w_g0;
  logic             w_g1;
  logic [PW-1:0]    w_g0_idx;
  logic [PW-1:0]    w_g1_idx;
  logic [PW-1:0]    w_idx;
  logic [N_REQ-1:0] w_ready;

  // Channel 1 skips candidates aimed at channel 0's register.
  always_comb begin
    w_g0     = 1'b0;
    w_g1     = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
    w_idx    = '0;
    w_ready  = '0;
    if (r_state == ST_RUN) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = PW'((int'(r_rr_ptr) + k) % N_REQ);
        if (req_valid[w_idx]) begin
          if (!w_g0) begin
            w_g0     = 1'b1;
            w_g0_idx = w_idx;
          end else if (!w_g1 &&
                       (w_sel[w_idx] != w_sel[w_g0_idx])) begin
            w_g1     = 1'b1;
            w_g1_idx = w_idx;
          end
        end
      end
    end
    if (w_g0) w_ready[w_g0_idx] = 1'b1;
    if (w_g1) w_ready[w_g1_idx] = 1'b1;
  end

  logic [PW-1:0] w_last;
  logic [PW-1:0] w_next_ptr;
  logic          w_we0;
  logic          w_we1;

  assign w_last     = w_g1 ? w_g1_idx : w_g0_idx;
  assign w_next_ptr = PW'((int'(w_last) + 1) % N_REQ);
  // x0 is hardwired zero: accept the request but suppress the write.
  assign w_we0 = w_g0 && (w_sel[w_g0_idx] != '0);
  assign w_we1 = w_g1 && (w_sel[w_g1_idx] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_rr_ptr    <= '0;
      r_wb_en     <= '0;
      r_wb_sel    <= '0;
      r_wb_data   <= '0;
      r_init_done <= 1'b0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_wb_en   <= 2'b11;
          r_wb_sel  <= {r_sweep, 1'b1, r_sweep, 1'b0};
          r_wb_data <= '0;
          r_sweep   <= r_sweep + CW'(1);
          if (&r_sweep) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
          r_wb_en     <= {w_we1, w_we0};
          if (w_we0) begin
            r_wb_sel[0 +: SEL_W]  <= w_sel[w_g0_idx];
            r_wb_data[0 +: X_LEN] <= w_data[w_g0_idx];
          end
          if (w_we1) begin
            r_wb_sel[SEL_W +: SEL_W]  <= w_sel[w_g1_idx];
            r_wb_data[X_LEN +: X_LEN] <= w_data[w_g1_idx];
          end
          if (w_g0) r_rr_ptr <= w_next_ptr;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign wb_en     = r_wb_en;
  assign wb_sel    = r_wb_sel;
  assign wb_data   = r_wb_data;
  assign init_done = r_init_done;

`ifdef REG_WB_STATS_EN
  logic [31:0] r_conf;
  logic        w_conf;

  assign w_conf = (r_state == ST_RUN) && |(req_valid & ~w_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conf <= '0;
    end else if (w_conf && (r_conf != 32'hFFFF_FFFF)) begin
      r_conf <= r_conf + 32'd1;
    end
  end

  assign stat_conflicts = r_conf;
`else
  assign stat_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: clear sweep, round-robin grants,
// same-select skip, x0 suppression, mid-sweep reset and stall counter.
module tb_reg_wb_arbiter;

  localparam int X_LEN = 32;
  localparam int N_REQ = 4;
  localparam int SEL_W = 7;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*SEL_W-1:0] req_sel;
  logic [N_REQ*X_LEN-1:0] req_data;
  logic [1:0]             wb_en;
  logic [2*SEL_W-1:0]     wb_sel;
  logic [2*X_LEN-1:0]     wb_data;
  logic                   init_done;
  logic [31:0]            stat_conflicts;

  int n_pass;
  int n_tot;

  reg_wb_arbiter #(
    .X_LEN(X_LEN),
    .N_REQ(N_REQ),
    .SEL_W(SEL_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_data      (req_data),
    .wb_en         (wb_en),
    .wb_sel        (wb_sel),
    .wb_data       (wb_data),
    .init_done     (init_done),
    .stat_conflicts(stat_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i,
                         input logic [SEL_W-1:0] s,
                         input logic [X_LEN-1:0] d);
    req_sel[i*SEL_W +: SEL_W]  = s;
    req_data[i*X_LEN +: X_LEN] = d;
  endtask

  task automatic run_sweep();
    logic [SEL_W-1:0] s0;
    logic [SEL_W-1:0] s1;
    for (int k = 0; k < 64; k++) begin
      tick();
      s0 = SEL_W'(2 * k);
      s1 = SEL_W'(2 * k + 1);
      chk("sweep", {wb_en, wb_sel, wb_data},
          {2'b11, s1, s0, 64'h0});
      if (k == 31) chk("init_noready", req_ready, 4'b0000);
    end
  endtask

  logic [31:0] exp_stat;

  initial begin
    n_pass    = 0;
    n_tot     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_sel   = '0;
    req_data  = '0;
`ifdef REG_WB_STATS_EN
    exp_stat = 32'd5;
`else
    exp_stat = 32'd0;
`endif

    #22;
    chk("rst_out", {wb_en, wb_sel, wb_data}, 80'h0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_stat", stat_conflicts, 32'd0);
    // pending during sweep, must wait for RUN
    set_req(3, 7'h10, 32'h33);
    req_valid = 4'b1000;
    rst_n = 1'b1;
    run_sweep();
    chk("first_run_ready", req_ready, 4'b1000);
    tick();
    chk("first_run_wb", {wb_en, wb_sel, wb_data},
        {2'b01, 7'h7F, 7'h10, 32'h0, 32'h33});
    chk("init_done", init_done, 1'b1);

    // two requests, distinct selects, rr_ptr=0
    req_valid = 4'b0101;
    set_req(0, 7'h21, 32'hA0);
    set_req(2, 7'h22, 32'hA2);
    #1;
    chk("pairA_ready", req_ready, 4'b0101);
    tick();
    chk("pairA_wb", {wb_en, wb_sel, wb_data},
        {2'b11, 7'h22, 7'h21, 32'hA2, 32'hA0});
    req_valid = 4'b0000;
    tick();
    chk("idle_hold", {wb_en, wb_sel, wb_data},
        {2'b00, 7'h22, 7'h21, 32'hA2, 32'hA0});

    // same-select skip, rr_ptr=3
    set_req(0, 7'h05, 32'hB0);
    set_req(1, 7'h05, 32'hB1);
    set_req(2, 7'h06, 32'hB2);
    req_valid = 4'b0111;
    #1;
    chk("skip_ready", req_ready, 4'b0101);
    tick();
    chk("skip_wb", {wb_en, wb_sel, wb_data},
        {2'b11, 7'h06, 7'h05, 32'hB2, 32'hB0});
    req_valid = 4'b0010;
    #1;
    chk("skip_next_ready", req_ready, 4'b0010);
    tick();
    chk("skip_next_wb", {wb_en, wb_sel, wb_data},
        {2'b01, 7'h06, 7'h05, 32'hB2, 32'hB1});

    // rr_ptr=2: single grant to req3 moves it to 0
    set_req(3, 7'h0A, 32'hC3);
    req_valid = 4'b1000;
    #1;
    chk("solo_ready", req_ready, 4'b1000);
    tick();

    // all four valid, held constant
    set_req(0, 7'h11, 32'hD0);
    set_req(1, 7'h12, 32'hD1);
    set_req(2, 7'h13, 32'hD2);
    set_req(3, 7'h14, 32'hD3);
    req_valid = 4'b1111;
    #1;
    chk("rr_ready0", req_ready, 4'b0011);
    tick();
    chk("rr_wb0", {wb_en, wb_sel, wb_data},
        {2'b11, 7'h12, 7'h11, 32'hD1, 32'hD0});
    chk("rr_ready1", req_ready, 4'b1100);
    tick();
    chk("rr_wb1", {wb_en, wb_sel, wb_data},
        {2'b11, 7'h14, 7'h13, 32'hD3, 32'hD2});
    chk("rr_ready2", req_ready, 4'b0011);
    req_valid = 4'b0000;
    tick();

    // x0 write: accepted, not written
    set_req(0, 7'h00, 32'hDEAD);
    req_valid = 4'b0001;
    #1;
    chk("x0_ready", req_ready, 4'b0001);
    tick();
    chk("x0_en", wb_en, 2'b00);
    req_valid = 4'b0000;
    tick();

    // reset in RUN, then again mid-sweep
    rst_n = 1'b0;
    #1;
    chk("rst2_out", {wb_en, wb_sel, wb_data, init_done}, 81'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_sweep", {wb_en, wb_sel}, {2'b11, 7'h13, 7'h12});
    rst_n = 1'b0;
    #1;
    chk("rst3_out", {wb_en, wb_sel, wb_data, init_done}, 81'h0);
    chk("rst3_stat", stat_conflicts, 32'd0);
    rst_n = 1'b1;
    run_sweep();

    // three valid for five cycles: one always stalls
    set_req(0, 7'h31, 32'hE0);
    set_req(1, 7'h32, 32'hE1);
    set_req(2, 7'h33, 32'hE2);
    req_valid = 4'b0111;
    for (int k = 0; k < 5; k++) tick();
    req_valid = 4'b0000;
    chk("stat5", stat_conflicts, exp_stat);
    tick();
    chk("stat_hold", stat_conflicts, exp_stat);
    chk("init_done2", init_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
